// File: rtl/lif_layer_if.sv
// lif_layer_if: step/current/select/clear inputs and spike/state/count outputs of a LIF layer
// Ports (via modports):
//   master drives step, current, sel, clr_cnt and receives spike, state_out, spike_cnt
//   slave receives step, current, sel, clr_cnt and drives spike, state_out, spike_cnt
interface lif_layer_if #(
  parameter int N_NEURONS = 4,
  parameter int WIDTH     = 8,
  parameter int CNT_W     = 16
);
  localparam int SEL_W = N_NEURONS > 1 ? $clog2(N_NEURONS) : 1;
  logic                        step;
  logic [N_NEURONS*WIDTH-1:0]  current;
  logic [SEL_W-1:0]            sel;
  logic                        clr_cnt;
  logic [N_NEURONS-1:0]        spike;
  logic [WIDTH-1:0]            state_out;
  logic [CNT_W-1:0]            spike_cnt;
  modport master (output step, current, sel, clr_cnt, input spike, state_out, spike_cnt);
  modport slave  (input step, current, sel, clr_cnt, output spike, state_out, spike_cnt);
endinterface

// File: rtl/lif_layer.sv
// lif_layer: layer of independent leaky integrate-and-fire neurons with refractory period and spike counter
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - slave side of lif_layer_if: step strobe, per-neuron currents, state select,
//          counter clear in; registered spike pulses, selected membrane state, spike count out
module lif_layer #(
  parameter int N_NEURONS  = 4,
  parameter int WIDTH      = 8,
  parameter int LEAK_SHIFT = 1,
  parameter int THRESHOLD  = 200,
  parameter int REFRAC     = 2,
  parameter int RESET_MODE = 1,
  parameter int CNT_W      = 16
) (
  input logic        clk,
  input logic        rst,
  lif_layer_if.slave bus
);
  localparam int RW = REFRAC > 0 ? $clog2(REFRAC + 1) : 1;
  logic [WIDTH-1:0]     r_state [N_NEURONS];
  logic [RW-1:0]        r_ref   [N_NEURONS];
  logic [N_NEURONS-1:0] r_spike;
  logic [CNT_W-1:0]     r_cnt;
  logic [WIDTH-1:0]     w_decay     [N_NEURONS];
  logic [WIDTH:0]       w_sum       [N_NEURONS];
  logic [WIDTH-1:0]     w_sat       [N_NEURONS];
  logic [WIDTH-1:0]     w_state_nxt [N_NEURONS];
  logic [RW-1:0]        w_ref_nxt   [N_NEURONS];
  logic [N_NEURONS-1:0] w_spike_nxt;
  logic [CNT_W-1:0]     w_pop;
  always_comb begin
    w_spike_nxt = '0;
    w_pop = '0;
    for (int i = 0; i < N_NEURONS; i++) begin
      w_decay[i] = r_state[i] - (r_state[i] >> LEAK_SHIFT);
      // one extra bit so the sum can be clamped instead of wrapping
      w_sum[i] = {1'b0, w_decay[i]} + {1'b0, bus.current[i*WIDTH +: WIDTH]};
      w_sat[i] = w_sum[i][WIDTH] ? '1 : w_sum[i][WIDTH-1:0];
      w_spike_nxt[i] = bus.step && r_ref[i] == '0 && w_sat[i] >= WIDTH'(THRESHOLD);
      w_state_nxt[i] = !bus.step ? r_state[i] :
                       r_ref[i] != '0 ? w_decay[i] :
                       w_spike_nxt[i] ? (RESET_MODE != 0 ? w_sat[i] - WIDTH'(THRESHOLD) : '0) :
                       w_sat[i];
      w_ref_nxt[i] = !bus.step ? r_ref[i] :
                     r_ref[i] != '0 ? r_ref[i] - 1'b1 :
                     w_spike_nxt[i] ? RW'(REFRAC) : '0;
      w_pop = w_pop + CNT_W'(w_spike_nxt[i]);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        r_state[i] <= '0;
        r_ref[i]   <= '0;
      end
      r_spike <= '0;
      r_cnt   <= '0;
    end else begin
      for (int i = 0; i < N_NEURONS; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_ref[i]   <= w_ref_nxt[i];
      end
      r_spike <= w_spike_nxt;
      // clear wins: spikes on the clearing edge are dropped from the count
      r_cnt   <= bus.clr_cnt ? '0 : r_cnt + w_pop;
    end
  end
  assign bus.spike     = r_spike;
  assign bus.spike_cnt = r_cnt;
  assign bus.state_out = 32'(bus.sel) < N_NEURONS ? r_state[bus.sel] : '0;
endmodule

// File: tb/tb_lif_layer.sv
// tb_lif_layer: directed self-checking bench for lif_layer (default build plus RESET_MODE=0/CNT_W=4 build)
module tb_lif_layer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  lif_layer_if #(.N_NEURONS(4), .WIDTH(8), .CNT_W(16)) ia ();
  lif_layer_if #(.N_NEURONS(4), .WIDTH(8), .CNT_W(4))  ib ();
  lif_layer dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
  lif_layer #(.RESET_MODE(0), .CNT_W(4)) dut_b (.clk(clk), .rst(rst), .bus(ib.slave));
  task automatic cyc_a(input logic st, input logic [31:0] cur, input logic clr);
    ia.step = st;
    ia.current = cur;
    ia.clr_cnt = clr;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic cyc_b(input logic st, input logic [31:0] cur, input logic clr);
    ib.step = st;
    ib.current = cur;
    ib.clr_cnt = clr;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic test_reset;
    repeat (2) @(negedge clk);
    vectors++;
    if (ia.spike !== 4'b0000) begin miscompares++; $display("FAIL reset_spike got %b want 0000", ia.spike); end
    vectors++;
    if (ia.state_out !== 8'd0) begin miscompares++; $display("FAIL reset_state got %0d want 0", ia.state_out); end
    vectors++;
    if (ia.spike_cnt !== 16'd0) begin miscompares++; $display("FAIL reset_cnt got %0d want 0", ia.spike_cnt); end
    vectors++;
    if (ib.spike_cnt !== 4'd0) begin miscompares++; $display("FAIL reset_cnt_b got %0d want 0", ib.spike_cnt); end
    rst = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_integrate;
    logic [7:0] exp_st [6] = '{8'd120, 8'd180, 8'd10, 8'd5, 8'd3, 8'd122};
    logic       exp_sp [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    ia.sel = 2'd0;
    for (int k = 0; k < 6; k++) begin
      cyc_a(1'b1, 32'd120, 1'b0);
      vectors++;
      if (ia.state_out !== exp_st[k]) begin miscompares++; $display("FAIL integ_state[%0d] got %0d want %0d", k, ia.state_out, exp_st[k]); end
      vectors++;
      if (ia.spike[0] !== exp_sp[k]) begin miscompares++; $display("FAIL integ_spike[%0d] got %b want %b", k, ia.spike[0], exp_sp[k]); end
    end
    vectors++;
    if (ia.spike_cnt !== 16'd1) begin miscompares++; $display("FAIL integ_cnt got %0d want 1", ia.spike_cnt); end
  endtask
  task automatic test_hold;
    for (int k = 0; k < 5; k++) begin
      cyc_a(1'b0, 32'hFFFF_FFFF, 1'b0);
      vectors++;
      if (ia.state_out !== 8'd122) begin miscompares++; $display("FAIL hold_state[%0d] got %0d want 122", k, ia.state_out); end
      vectors++;
      if (ia.spike !== 4'b0000) begin miscompares++; $display("FAIL hold_spike[%0d] got %b want 0000", k, ia.spike); end
      vectors++;
      if (ia.spike_cnt !== 16'd1) begin miscompares++; $display("FAIL hold_cnt[%0d] got %0d want 1", k, ia.spike_cnt); end
    end
  endtask
  task automatic test_saturate;
    ia.sel = 2'd1;
    cyc_a(1'b1, 32'h0000_FF00, 1'b0);
    vectors++;
    if (ia.state_out !== 8'd55) begin miscompares++; $display("FAIL sat_state got %0d want 55", ia.state_out); end
    vectors++;
    if (ia.spike !== 4'b0010) begin miscompares++; $display("FAIL sat_spike got %b want 0010", ia.spike); end
    vectors++;
    if (ia.spike_cnt !== 16'd2) begin miscompares++; $display("FAIL sat_cnt got %0d want 2", ia.spike_cnt); end
  endtask
  task automatic test_all_channels;
    repeat (2) cyc_a(1'b1, 32'd0, 1'b0);
    cyc_a(1'b1, 32'hFFFF_FFFF, 1'b0);
    vectors++;
    if (ia.spike !== 4'b1111) begin miscompares++; $display("FAIL all_spike got %b want 1111", ia.spike); end
    vectors++;
    if (ia.spike_cnt !== 16'd6) begin miscompares++; $display("FAIL all_cnt got %0d want 6", ia.spike_cnt); end
    vectors++;
    if (ia.state_out !== 8'd55) begin miscompares++; $display("FAIL all_state got %0d want 55", ia.state_out); end
    cyc_a(1'b0, 32'd0, 1'b0);
    vectors++;
    if (ia.spike !== 4'b0000) begin miscompares++; $display("FAIL all_pulse got %b want 0000", ia.spike); end
    vectors++;
    if (ia.spike_cnt !== 16'd6) begin miscompares++; $display("FAIL all_cnt_hold got %0d want 6", ia.spike_cnt); end
    repeat (2) cyc_a(1'b1, 32'd0, 1'b0);
    cyc_a(1'b1, 32'hFFFF_FFFF, 1'b1);
    vectors++;
    if (ia.spike !== 4'b1111) begin miscompares++; $display("FAIL clr_spike got %b want 1111", ia.spike); end
    vectors++;
    if (ia.spike_cnt !== 16'd0) begin miscompares++; $display("FAIL clr_cnt got %0d want 0", ia.spike_cnt); end
    cyc_a(1'b0, 32'd0, 1'b0);
    vectors++;
    if (ia.spike_cnt !== 16'd0) begin miscompares++; $display("FAIL clr_cnt_after got %0d want 0", ia.spike_cnt); end
  endtask
  task automatic test_async_reset;
    repeat (2) cyc_a(1'b1, 32'd0, 1'b0);
    ia.sel = 2'd0;
    cyc_a(1'b1, 32'd255, 1'b0);
    vectors++;
    if (ia.spike !== 4'b0001) begin miscompares++; $display("FAIL pre_rst_spike got %b want 0001", ia.spike); end
    vectors++;
    if (ia.spike_cnt !== 16'd1) begin miscompares++; $display("FAIL pre_rst_cnt got %0d want 1", ia.spike_cnt); end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (ia.spike !== 4'b0000) begin miscompares++; $display("FAIL arst_spike got %b want 0000", ia.spike); end
    vectors++;
    if (ia.state_out !== 8'd0) begin miscompares++; $display("FAIL arst_state got %0d want 0", ia.state_out); end
    vectors++;
    if (ia.spike_cnt !== 16'd0) begin miscompares++; $display("FAIL arst_cnt got %0d want 0", ia.spike_cnt); end
    #1 rst = 1'b0;
    cyc_a(1'b1, 32'd120, 1'b0);
    vectors++;
    if (ia.state_out !== 8'd120) begin miscompares++; $display("FAIL post_rst_state got %0d want 120", ia.state_out); end
    vectors++;
    if (ia.spike !== 4'b0000) begin miscompares++; $display("FAIL post_rst_spike got %b want 0000", ia.spike); end
  endtask
  task automatic test_sel;
    ia.sel = 2'd3;
    cyc_a(1'b1, 32'd50 << 24, 1'b0);
    vectors++;
    if (ia.state_out !== 8'd50) begin miscompares++; $display("FAIL sel3_first got %0d want 50", ia.state_out); end
    cyc_a(1'b1, 32'd50 << 24, 1'b0);
    vectors++;
    if (ia.state_out !== 8'd75) begin miscompares++; $display("FAIL sel3_second got %0d want 75", ia.state_out); end
  endtask
  task automatic test_reset_mode_zero;
    ib.sel = 2'd1;
    cyc_b(1'b1, 32'h0000_FF00, 1'b0);
    vectors++;
    if (ib.spike !== 4'b0010) begin miscompares++; $display("FAIL rm0_spike got %b want 0010", ib.spike); end
    vectors++;
    if (ib.state_out !== 8'd0) begin miscompares++; $display("FAIL rm0_state got %0d want 0", ib.state_out); end
    vectors++;
    if (ib.spike_cnt !== 4'd1) begin miscompares++; $display("FAIL rm0_cnt got %0d want 1", ib.spike_cnt); end
  endtask
  task automatic test_cnt_wrap;
    logic [3:0] exp_cnt [4] = '{4'd5, 4'd9, 4'd13, 4'd1};
    for (int g = 0; g < 4; g++) begin
      repeat (2) cyc_b(1'b1, 32'd0, 1'b0);
      cyc_b(1'b1, 32'hFFFF_FFFF, 1'b0);
      vectors++;
      if (ib.spike !== 4'b1111) begin miscompares++; $display("FAIL wrap_spike[%0d] got %b want 1111", g, ib.spike); end
      vectors++;
      if (ib.spike_cnt !== exp_cnt[g]) begin miscompares++; $display("FAIL wrap_cnt[%0d] got %0d want %0d", g, ib.spike_cnt, exp_cnt[g]); end
    end
  endtask
  initial begin
    ia.step = 1'b0; ia.current = '0; ia.sel = '0; ia.clr_cnt = 1'b0;
    ib.step = 1'b0; ib.current = '0; ib.sel = '0; ib.clr_cnt = 1'b0;
    test_reset();
    test_integrate();
    test_hold();
    test_saturate();
    test_all_channels();
    test_async_reset();
    test_sel();
    test_reset_mode_zero();
    test_cnt_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/lif_layer.md
Name: lif_layer

Overview:
- Parametrised layer of N_NEURONS independent leaky integrate-and-fire neurons.
- Generalises the single-neuron LIF with:
  - configurable width, leak and threshold
  - refractory period
  - selectable reset mode
  - a global step strobe
- Adds a layer-wide spike counter and a channel-select state readout for the tt_um top-level pins.

Parameters:
- N_NEURONS, 4, number of neurons (≥1)
- WIDTH, 8, membrane state and per-neuron current width (unsigned)
- LEAK_SHIFT, 1, leak k: decay(s) = s - (s >> k); k in 1..WIDTH-1
- THRESHOLD, 200, firing threshold (1..2^WIDTH-1)
- REFRAC, 2, refractory length in steps (0 = none)
- RESET_MODE, 1, 1 = subtract threshold on spike, 0 = reset to zero
- CNT_W, 16, spike counter width

Ports:
- clk, input, 1, clock; all state updates on rising edge
- rst, input, 1, asynchronous active-high reset
- step, input, 1, update strobe; neurons advance only on cycles where step=1
- current, input, N_NEURONS*WIDTH, neuron i input current = current[i*WIDTH +: WIDTH]
- sel, input, max(1,$clog2(N_NEURONS)), neuron index for state_out
- clr_cnt, input, 1, synchronous clear of spike_cnt
- spike, output, N_NEURONS, registered spike pulses
- state_out, output, WIDTH, membrane state of neuron sel
- spike_cnt, output, CNT_W, total spikes emitted since reset/clear

Behaviour:
- Reset: clk, rst is the only asynchronous path. While rst=1:
  - all membrane states = 0
  - refractory counters = 0
  - spike = 0
  - spike_cnt = 0
- Per neuron i on a rising edge with step=1, refractory counter r_i = 0:
  - sum = decay(state_i) + current_i, computed in WIDTH+1 bits
  - sat = min(sum, 2^WIDTH-1)
  - if sat ≥ THRESHOLD:
    - spike[i] <= 1
    - state_i <= (RESET_MODE ? sat - THRESHOLD : 0)
    - r_i <= REFRAC
  - else: spike[i] <= 0, state_i <= sat
- Step with r_i > 0:
  - current_i ignored
  - state_i <= decay(state_i)
  - r_i <= r_i - 1
  - spike[i] <= 0
- Edge with step=0:
  - states and r_i hold
  - spike <= 0, so spike pulses last exactly one clock
- Latency: current sampled on the step edge; spike and new state visible after that edge (1 cycle).
- state_out:
  - combinational mux of registered states
  - sel ≥ N_NEURONS gives 0
- spike_cnt:
  - each edge, spike_cnt <= spike_cnt + popcount(next spike vector)
  - wraps modulo 2^CNT_W
  - clr_cnt=1 forces 0 and wins over simultaneous spikes (those spikes are not counted)
- Neurons are fully independent. Simultaneous spikes on multiple channels are all counted in the same cycle.
- rst asserted mid-operation:
  - immediate clear, including in-progress refractory periods
  - first step after release starts from state 0

Test Plan (defaults: N=4, WIDTH=8, LEAK_SHIFT=1, THRESHOLD=200, REFRAC=2, RESET_MODE=1):
1. ch0 current=120, step every cycle, sel=0 -> state_out 120, 180, then spike[0]=1 with state 10. Refractory steps give 5 and 3 with spike=0. Next step gives 122. spike_cnt=1.
2. ch1 current=255 for one step -> saturates to 255, spike[1]=1, state 55. With RESET_MODE=0 rebuild, state 0 instead.
3. step=0 for 5 cycles after scenario 1 with current=255 on all channels -> states unchanged, spike stays 0, spike_cnt unchanged.
4. All four channels current=255 on one step -> spike=4'b1111 for one cycle, spike_cnt += 4. Same step with clr_cnt=1 -> spike_cnt=0.
5. rst pulsed asynchronously (between clock edges) while ch0 is refractory -> spike, states and spike_cnt go 0 immediately. After release, current=120 gives state 120 on the first step (no refractory carried over).
6. sel=3 with ch3 driven 50 for 2 steps -> state_out 50, then 75. spike_cnt wrap with CNT_W=4: 17 spikes yields 1.
